// File: rtl/param_bit_sorter_pkg.sv
// Shared types and helpers for the serial bit sorter.
`timescale 1ns/1ps
package sorter_pkg;

  // Two-state sequencer: waiting for a word, or streaming one out.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Counter width that can index n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/param_bit_sorter_popcount.sv
// Combinational ones counter for a WIDTH-bit word.
`timescale 1ns/1ps
module popcount #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]             in,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int CW = $clog2(WIDTH+1);

  // Sum every bit of the word into the running count.
  always_comb begin
    // NOTE: blocking assignments here build a chain of adders evaluated in
    // order; each iteration must see the previous partial sum immediately.
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(in[i]);
    end
  end

endmodule

// File: rtl/param_bit_sorter.sv
// Serial binary sorter: latches a word, then streams its bits one per clock,
// zeros-first or ones-first, with a popcount output and back-to-back loading.
`timescale 1ns/1ps
module param_bit_sorter
  import sorter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                         ck,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in,
  input  logic                         ld,
  input  logic                         desc,
  output logic                         rdy,
  output logic                         VO,
  output logic                         out,
  output logic                         last,
  output logic [$clog2(WIDTH+1)-1:0]   ones
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int IW = clog2_min1(WIDTH);
  // Compare width: one spare bit so WIDTH itself is representable.
  localparam int EW = CW + 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q,   idx_d;
  logic [CW-1:0]   ones_q,  ones_d;
  logic            desc_q,  desc_d;

  logic [CW-1:0]   pop_count;
  logic            emit;
  logic            last_idx;
  logic            load_acc;
  logic [EW-1:0]   idx_x;
  logic [EW-1:0]   ones_x;
  logic [EW-1:0]   thresh_x;

  popcount #(.WIDTH(WIDTH)) u_popcount (
    .in    (in),
    .count (pop_count)
  );

  // Handshake and index decode; rdy depends on state only, never on ld.
  assign emit     = (state_q == EMIT);
  assign last_idx = (idx_q == IW'(WIDTH - 1));
  assign rdy      = !emit || last_idx;
  assign load_acc = ld && rdy;

  // Zeros-first: a bit is 1 once idx reaches WIDTH-ones.
  // Ones-first:  a bit is 1 while idx is below ones.
  assign idx_x    = EW'(idx_q);
  assign ones_x   = EW'(ones_q);
  assign thresh_x = EW'(WIDTH) - ones_x;

  assign VO   = emit;
  assign out  = emit && (desc_q ? (idx_x < ones_x) : (idx_x >= thresh_x));
  assign last = emit && last_idx;
  assign ones = ones_q;

  // Next-state logic: accept a load, advance the index, or drop back to IDLE.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    ones_d  = ones_q;
    desc_d  = desc_q;
    if (load_acc) begin
      state_d = EMIT;
      idx_d   = '0;
      ones_d  = pop_count;
      desc_d  = desc;
    end else if (emit) begin
      if (last_idx) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d   = idx_q + IW'(1);
      end
    end
  end

  // State registers with synchronous reset taking priority over any load.
  always_ff @(posedge ck) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ones_q  <= '0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      desc_q  <= desc_d;
    end
  end

endmodule
